// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan driver and its decoder.
package seg_pkg;
    typedef enum logic {SHOW = 1'b0, GAP = 1'b1} scan_state_t;

    localparam int NIB_W      = 4;
    localparam int MAX_DIGITS = 8;
    localparam logic [MAX_DIGITS-1:0] DIGIT_OFF = '1;
endpackage

// File: rtl/seg_scan_prescaler.sv
// Modulo-MOD counter with synchronous clear, count enable and a
// terminal-count pulse that is high only on an enabled last count.
module seg_scan_prescaler
    import seg_pkg::*;
#(
    parameter int MOD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = (MOD > 1) ? $clog2(MOD) : 1;
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt;

    assign tc = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit scan driver with dead time between digits and a
// pending/live word pair so the displayed value only changes at frame start.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int CLK_DIV  = 50000,
    parameter int DEAD_CYC = 8,
    parameter int LZ_BLANK = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [NIB_W*N_DIGITS-1:0] data_in,
    output logic                      load_ack,
    output logic                      pending,
    output logic [NIB_W-1:0]          nibble,
    output logic [N_DIGITS-1:0]       digit_sel,
    output logic                      frame_done
);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] OFF      = DIGIT_OFF[N_DIGITS-1:0];

    scan_state_t state, state_nx;
    logic [IDX_W-1:0]          idx;
    logic [NIB_W*N_DIGITS-1:0] live, pend_word;
    logic                      show_tc, gap_tc, wrap, promote;
    logic [N_DIGITS-1:0]       blank;
    logic                      upper_zero;
    logic [NIB_W-1:0]          cur_nib;

    seg_scan_prescaler #(.MOD(CLK_DIV)) u_show_ps (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != SHOW),
        .en    (en && state == SHOW),
        .tc    (show_tc)
    );

    seg_scan_prescaler #(.MOD(DEAD_CYC)) u_gap_ps (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != GAP),
        .en    (en && state == GAP),
        .tc    (gap_tc)
    );

    always_comb begin
        state_nx = state;
        case (state)
            SHOW:    if (show_tc) state_nx = GAP;
            GAP:     if (gap_tc)  state_nx = SHOW;
            default: state_nx = SHOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= SHOW;
        else
            state <= state_nx;
    end

    // Both terminal counts already include en, so a frozen scan never wraps.
    assign wrap    = gap_tc && (idx == LAST_IDX);
    assign promote = wrap && pending;

    always_ff @(posedge clk) begin
        if (!rst_n)
            idx <= '0;
        else if (gap_tc)
            idx <= wrap ? '0 : idx + IDX_W'(1);
    end

    // A load coinciding with promotion becomes the next pending word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live      <= '0;
            pend_word <= '0;
            pending   <= 1'b0;
        end else begin
            if (promote) begin
                live    <= pend_word;
                pending <= load;
            end else if (load) begin
                pending <= 1'b1;
            end
            if (load)
                pend_word <= data_in;
        end
    end

    // Walk from the top digit down; a digit is blank once everything above
    // and including it is zero. Digit 0 always stays lit.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero && (live[NIB_W*i +: NIB_W] == '0);
            blank[i]   = (LZ_BLANK != 0) && upper_zero;
        end
    end

    always_comb begin
        cur_nib = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (idx == IDX_W'(i))
                cur_nib = live[NIB_W*i +: NIB_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nibble     <= '0;
            digit_sel  <= OFF;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            load_ack   <= promote;
            frame_done <= show_tc && (idx == LAST_IDX);
            if (en && state == SHOW) begin
                nibble    <= cur_nib;
                digit_sel <= blank[idx] ? OFF : ~(N_DIGITS'(1) << idx);
            end else begin
                digit_sel <= OFF;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench: two drivers (leading-zero blanking off/on) share all inputs;
// each frame step is checked against hand-written digit/select tables.
module tb_seg_scan_driver;
    logic        clk, rst_n, en, load;
    logic [15:0] data_in;
    logic        ack0, ack1, pend0, pend1, fd0, fd1;
    logic [3:0]  nib0, nib1, sel0, sel1;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] sel_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seg_scan_driver #(.N_DIGITS(4), .CLK_DIV(4), .DEAD_CYC(1), .LZ_BLANK(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data_in(data_in),
        .load_ack(ack0), .pending(pend0), .nibble(nib0), .digit_sel(sel0),
        .frame_done(fd0)
    );

    seg_scan_driver #(.N_DIGITS(4), .CLK_DIV(4), .DEAD_CYC(1), .LZ_BLANK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data_in(data_in),
        .load_ack(ack1), .pending(pend1), .nibble(nib1), .digit_sel(sel1),
        .frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // d = digit slot, c = 0..3 show cycles, 4 = dead-time cycle
    task automatic chk_slot(input string tag, input logic [15:0] word, input logic [3:0] blank1,
                            input int d, input int c, input logic ack_e, input logic pend_e);
        logic [3:0] s0, s1, n;
        logic       fd_e;
        s0   = (c == 4) ? 4'hF : sel_tab[d];
        s1   = (c == 4 || blank1[d]) ? 4'hF : sel_tab[d];
        n    = word[4*d +: 4];
        fd_e = (d == 3) && (c == 3);
        chk({tag, " sel0"}, {4'h0, sel0}, {4'h0, s0});
        chk({tag, " sel1"}, {4'h0, sel1}, {4'h0, s1});
        chk({tag, " nib0"}, {4'h0, nib0}, {4'h0, n});
        if (!blank1[d])
            chk({tag, " nib1"}, {4'h0, nib1}, {4'h0, n});
        chk({tag, " fd0"},   {7'h0, fd0},   {7'h0, fd_e});
        chk({tag, " fd1"},   {7'h0, fd1},   {7'h0, fd_e});
        chk({tag, " ack0"},  {7'h0, ack0},  {7'h0, ack_e});
        chk({tag, " ack1"},  {7'h0, ack1},  {7'h0, ack_e});
        chk({tag, " pend0"}, {7'h0, pend0}, {7'h0, pend_e});
        chk({tag, " pend1"}, {7'h0, pend1}, {7'h0, pend_e});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " sel0"},  {4'h0, sel0}, 8'h0F);
        chk({tag, " sel1"},  {4'h0, sel1}, 8'h0F);
        chk({tag, " nib0"},  {4'h0, nib0}, 8'h00);
        chk({tag, " nib1"},  {4'h0, nib1}, 8'h00);
        chk({tag, " ack0"},  {7'h0, ack0},  8'h00);
        chk({tag, " pend0"}, {7'h0, pend0}, 8'h00);
        chk({tag, " pend1"}, {7'h0, pend1}, 8'h00);
        chk({tag, " fd0"},   {7'h0, fd0},   8'h00);
    endtask

    // One 20-cycle frame; la/lb are the edges at which load is asserted.
    task automatic run_frame(input int f, input logic [15:0] word, input logic [3:0] blank1,
                             input int la, input logic [15:0] da,
                             input int lb, input logic [15:0] db,
                             input logic pend_in, output logic pend_out);
        logic p, ld, ack_e;
        p = pend_in;
        for (int j = 0; j < 20; j++) begin
            if (j == la) begin load = 1'b1; data_in = da; end
            if (j == lb) begin load = 1'b1; data_in = db; end
            step();
            ld   = load;
            load = 1'b0;
            ack_e = (j == 19) && p;
            if (ack_e) p = ld;
            else       p = p | ld;
            chk_slot($sformatf("F%0d j%0d", f, j), word, blank1, j / 5, j % 5, ack_e, p);
        end
        pend_out = p;
    endtask

    logic pnd;

    initial begin
        rst_n = 1'b0; en = 1'b1; load = 1'b0; data_in = 16'h0000;
        step();
        step();
        chk_reset("reset");
        rst_n = 1'b1;

        // first frame shows the reset word; 1234 is captured and promoted at the wrap
        run_frame(1, 16'h0000, 4'b1110,  0, 16'h1234, -1, 16'h0, 1'b0, pnd);
        run_frame(2, 16'h1234, 4'b0000, -1, 16'h0,    -1, 16'h0, pnd,  pnd);
        run_frame(3, 16'h1234, 4'b0000,  8, 16'hABCD, -1, 16'h0, pnd,  pnd);
        run_frame(4, 16'hABCD, 4'b0000,  3, 16'h1111, 12, 16'h2222, pnd, pnd);
        // second load lands on the promotion edge: ack for 5678, 9ABC stays pending
        run_frame(5, 16'h2222, 4'b0000,  5, 16'h5678, 19, 16'h9ABC, pnd, pnd);
        chk("F5 end pending", {7'h0, pend0}, 8'h01);
        run_frame(6, 16'h5678, 4'b0000, -1, 16'h0,    -1, 16'h0, pnd,  pnd);
        run_frame(7, 16'h9ABC, 4'b0000,  6, 16'h0050, -1, 16'h0, pnd,  pnd);
        run_frame(8, 16'h0050, 4'b1100,  6, 16'h0000, -1, 16'h0, pnd,  pnd);
        run_frame(9, 16'h0000, 4'b1110,  4, 16'h1234, -1, 16'h0, pnd,  pnd);

        // freeze mid-show of digit 2 for 7 cycles
        for (int j = 0; j < 12; j++) begin
            step();
            chk_slot($sformatf("F10 j%0d", j), 16'h1234, 4'b0000, j / 5, j % 5, 1'b0, 1'b0);
        end
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("EN off k%0d sel0", k), {4'h0, sel0}, 8'h0F);
            chk($sformatf("EN off k%0d sel1", k), {4'h0, sel1}, 8'h0F);
            chk($sformatf("EN off k%0d nib0", k), {4'h0, nib0}, 8'h02);
            chk($sformatf("EN off k%0d fd0", k),  {7'h0, fd0},  8'h00);
        end
        en = 1'b1;
        step(); chk_slot("EN r1", 16'h1234, 4'b0000, 2, 2, 1'b0, 1'b0);
        step(); chk_slot("EN r2", 16'h1234, 4'b0000, 2, 3, 1'b0, 1'b0);
        step(); chk_slot("EN r3", 16'h1234, 4'b0000, 2, 4, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk_slot($sformatf("EN d3 c%0d", c), 16'h1234, 4'b0000, 3, c, 1'b0, 1'b0);
        end

        // reset in the dead time of digit 1 with a word pending
        for (int j = 0; j < 9; j++) begin
            if (j == 2) begin load = 1'b1; data_in = 16'h5555; end
            step();
            load = 1'b0;
            chk_slot($sformatf("F11 j%0d", j), 16'h1234, 4'b0000, j / 5, j % 5, 1'b0, j >= 2);
        end
        rst_n = 1'b0;
        step();
        chk_reset("mid reset");
        rst_n = 1'b1;
        run_frame(12, 16'h0000, 4'b1110, -1, 16'h0, -1, 16'h0, 1'b0, pnd);
        chk("F12 end pending", {7'h0, pend0}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
